// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module : uart_rx
// Desc   : 16x-oversampled UART receiver with a ready/valid holding register.
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int                 c_BIT_W     = $clog2(DATA_BITS);
  localparam logic [4:0]         c_MID_START = 5'd7;
  localparam logic [4:0]         c_LAST_DATA = 5'd15;
  localparam logic [4:0]         c_LAST_STOP = 5'(STOP_TICKS - 1);
  localparam logic [c_BIT_W-1:0] c_LAST_BIT  = c_BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rx_s;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [4:0]           r_tick_cnt;
  logic [4:0]           w_tick_nxt;
  logic [c_BIT_W-1:0]   r_bit_cnt;
  logic [c_BIT_W-1:0]   w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_word_done;
  logic                 w_frame_bad;

  // Synchroniser presets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_word_done = 1'b0;
    w_frame_bad = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = S_START;
          w_tick_nxt  = '0;
        end
      end
      S_START: begin
        if (sample_tick) begin
          if (r_tick_cnt == c_MID_START) begin
            w_tick_nxt  = '0;
            w_bit_nxt   = '0;
            w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
          end else begin
            w_tick_nxt = r_tick_cnt + 5'd1;
          end
        end
      end
      S_DATA: begin
        if (sample_tick) begin
          if (r_tick_cnt == c_LAST_DATA) begin
            w_tick_nxt  = '0;
            w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == c_LAST_BIT) begin
              w_state_nxt = S_STOP;
            end else begin
              w_bit_nxt = r_bit_cnt + 1'b1;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 5'd1;
          end
        end
      end
      S_STOP: begin
        if (sample_tick) begin
          if (r_tick_cnt == c_LAST_STOP) begin
            w_state_nxt = S_IDLE;
            w_tick_nxt  = '0;
            w_word_done = w_rx_s;
            w_frame_bad = !w_rx_s;
          end else begin
            w_tick_nxt = r_tick_cnt + 5'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A completing word may replace the held one only if it is drained on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= w_frame_bad;
      overrun_err <= 1'b0;
      if (w_word_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= r_shift;
          rx_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// Bench for uart_rx: frames are described at bit level, expected words/events go
// into queues, and a monitor scores every handshake and error pulse against them.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx7 = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun_err;
  logic [6:0] rx_data7;
  logic       rx_valid7, frame_err7, overrun_err7;

  uart_rx dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun_err(overrun_err)
  );

  uart_rx #(.DATA_BITS(7), .STOP_TICKS(32)) dut7 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx(rx7),
    .rx_data(rx_data7), .rx_valid(rx_valid7), .rx_ready(rx_ready),
    .frame_err(frame_err7), .overrun_err(overrun_err7)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 sample_tick = 1'b1;
      @(posedge clk);
      #1 sample_tick = 1'b0;
    end
  end

  logic [7:0] q_data[$];
  logic [6:0] q_data7[$];
  bit         q_ferr[$];
  bit         q_ferr7[$];
  bit         q_ovr[$];
  int         checks = 0;
  int         errors = 0;
  bit         stim_done = 1'b0;
  bit         final_done = 1'b0;

  // Monitor / scoreboard
  initial begin
    logic [7:0] e8;
    logic [6:0] e7;
    bit         dummy;
    forever begin
      @(negedge clk);
      if (!reset) begin
        checks++;
        if ({rx_data, rx_valid, frame_err, overrun_err} != '0 ||
            {rx_data7, rx_valid7, frame_err7, overrun_err7} != '0) begin
          errors++;
          $display("FAIL reset_state: data=%h valid=%b ferr=%b ovr=%b data7=%h valid7=%b ferr7=%b ovr7=%b, all required 0",
                   rx_data, rx_valid, frame_err, overrun_err, rx_data7, rx_valid7, frame_err7, overrun_err7);
        end
      end else begin
        if (rx_valid && rx_ready) begin
          checks++;
          if (q_data.size() == 0) begin
            errors++;
            $display("FAIL word: got %h, no word expected", rx_data);
          end else begin
            e8 = q_data.pop_front();
            if (rx_data !== e8) begin
              errors++;
              $display("FAIL word: got %h, expected %h", rx_data, e8);
            end
          end
        end
        if (frame_err) begin
          checks++;
          if (q_ferr.size() == 0) begin
            errors++;
            $display("FAIL frame_err: got pulse, expected none");
          end else dummy = q_ferr.pop_front();
        end
        if (overrun_err) begin
          checks++;
          if (q_ovr.size() == 0) begin
            errors++;
            $display("FAIL overrun_err: got pulse, expected none");
          end else dummy = q_ovr.pop_front();
        end
        if (rx_valid7 && rx_ready) begin
          checks++;
          if (q_data7.size() == 0) begin
            errors++;
            $display("FAIL word7: got %h, no word expected", rx_data7);
          end else begin
            e7 = q_data7.pop_front();
            if (rx_data7 !== e7) begin
              errors++;
              $display("FAIL word7: got %h, expected %h", rx_data7, e7);
            end
          end
        end
        if (frame_err7) begin
          checks++;
          if (q_ferr7.size() == 0) begin
            errors++;
            $display("FAIL frame_err7: got pulse, expected none");
          end else dummy = q_ferr7.pop_front();
        end
        if (overrun_err7) begin
          checks++;
          errors++;
          $display("FAIL overrun_err7: got pulse, expected none");
        end
      end
      if (stim_done && !final_done) begin
        checks += 2;
        if (q_data.size() + q_ferr.size() + q_ovr.size() != 0) begin
          errors++;
          $display("FAIL leftover: got words=%0d ferr=%0d ovr=%0d still pending, expected 0",
                   q_data.size(), q_ferr.size(), q_ovr.size());
        end
        if (q_data7.size() + q_ferr7.size() != 0) begin
          errors++;
          $display("FAIL leftover7: got words=%0d ferr=%0d still pending, expected 0",
                   q_data7.size(), q_ferr7.size());
        end
        final_done = 1'b1;
      end
    end
  end

  task automatic wait_tick();
    @(posedge clk);
    while (!sample_tick) @(posedge clk);
  endtask

  task automatic idle(input int k);
    repeat (k) wait_tick();
    #1;
  endtask

  // Line level at tick n of a frame: 16 ticks per bit; the stop field is high
  // except for ticks in [shi, slo) relative to its start.
  function automatic logic line_at(int n, int nb, logic [7:0] d, int stot, int shi, int slo);
    int rel;
    rel = n - 16 - 16 * nb;
    if (n < 16) return 1'b0;
    if (rel < 0) return d[(n - 16) / 16];
    if (rel >= stot) return 1'b1;
    return (rel < shi) || (rel >= slo);
  endfunction

  task automatic send(input bit sel, input logic [7:0] d, input int shi, input int slo,
                      input int idle_ticks, input bit drain, input int abort_at);
    int   nb, stot, total, done_tick;
    logic v;
    nb        = sel ? 7 : 8;
    stot      = sel ? 32 : 16;
    total     = 16 + 16 * nb + stot + idle_ticks;
    done_tick = 8 + 16 * nb + stot;
    wait_tick();
    for (int n = 0; n < total; n++) begin
      #1;
      v = line_at(n, nb, d, stot, shi, slo);
      if (sel) rx7 = v; else rx = v;
      if (n == abort_at) begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        rx  = 1'b1;
        rx7 = 1'b1;
        break;
      end else if (drain && n == done_tick - 1) begin
        repeat (3) @(posedge clk);
        #1 rx_ready = 1'b1;
        wait_tick();
        #1 rx_ready = 1'b0;
      end else begin
        wait_tick();
      end
    end
    #1;
  endtask

  initial begin
    logic [7:0] rd;
    bit         rok;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    idle(4);

    q_data.push_back(8'hA5);
    send(0, 8'hA5, 0, 0, 8, 0, -1);

    wait_tick();
    #1 rx = 1'b0;
    repeat (5) wait_tick();
    #1 rx = 1'b1;
    idle(20);
    q_data.push_back(8'h3C);
    send(0, 8'h3C, 0, 0, 8, 0, -1);

    q_ferr.push_back(1'b1);
    send(0, 8'h55, 0, 10, 8, 0, -1);

    // Backpressure: second word is dropped as an overrun
    rx_ready = 1'b0;
    q_data.push_back(8'h11);
    q_ovr.push_back(1'b1);
    send(0, 8'h11, 0, 0, 0, 0, -1);
    send(0, 8'h22, 0, 0, 8, 0, -1);
    rx_ready = 1'b1;
    idle(4);

    // Drain coincident with completion replaces the held word
    rx_ready = 1'b0;
    q_data.push_back(8'h11);
    q_data.push_back(8'h22);
    send(0, 8'h11, 0, 0, 4, 0, -1);
    send(0, 8'h22, 0, 0, 8, 1, -1);
    rx_ready = 1'b1;
    idle(4);

    // Reset mid-frame discards both held and partial words
    rx_ready = 1'b0;
    send(0, 8'h99, 0, 0, 8, 0, -1);
    send(0, 8'hFF, 0, 0, 0, 0, 72);
    rx_ready = 1'b1;
    idle(20);
    q_data.push_back(8'h81);
    send(0, 8'h81, 0, 0, 8, 0, -1);

    for (int i = 0; i < 20; i++) begin
      rd  = 8'($urandom);
      rok = ($urandom_range(0, 4) != 0);
      if (rok) begin
        q_data.push_back(rd);
        send(0, rd, 0, 0, int'($urandom_range(0, 6)), 0, -1);
      end else begin
        q_ferr.push_back(1'b1);
        send(0, rd, 0, 10, 8, 0, -1);
      end
    end

    // 7-bit / two-stop-bit instance
    q_data7.push_back(7'h5A);
    send(1, 8'h5A, 0, 0, 8, 0, -1);
    q_ferr7.push_back(1'b1);
    send(1, 8'h7F, 16, 26, 8, 0, -1);
    q_data7.push_back(7'h33);
    send(1, 8'h33, 0, 0, 8, 0, -1);

    idle(8);
    stim_done = 1'b1;
    wait (final_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: stimulus still running, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
